aes_block_sequencer: RTL and testbench

AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_block_sequencer_if.sv | 26 ++
 rtl/aes_block_sequencer.sv | 96 +++++++++
 tb/tb_aes_block_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block sequencer: FSM states,
// block geometry and a helper that extracts one 32-bit word of a block.
package aes_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN
  } seq_state_e;

  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [31:0] block_word(input logic [127:0] blk, input word_idx_t idx);
    return blk[(WORDS_PER_BLOCK - 1 - int'(idx)) * 32 +: 32];
  endfunction

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Word stream in/out plus the cipher-core load/done bus of the sequencer.
// The master modport is the sequencer's view; slave is the environment's.
interface aes_block_sequencer_if;

  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         aes_ld;
  logic [127:0] aes_text_in;
  logic         aes_done;
  logic [127:0] aes_text_out;

  modport master (
    input  s_data, s_valid, m_ready, aes_done, aes_text_out,
    output s_ready, m_data, m_valid, aes_ld, aes_text_in
  );

  modport slave (
    output s_data, s_valid, m_ready, aes_done, aes_text_out,
    input  s_ready, m_data, m_valid, aes_ld, aes_text_in
  );

endinterface

// File: rtl/aes_block_sequencer.sv
// Packs four 32-bit words into a 128-bit block, hands it to an external AES
// core, waits (with timeout) for the result and streams it out as four words.
module aes_block_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_block_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int        TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam word_idx_t LAST_IDX = word_idx_t'(WORDS_PER_BLOCK - 1);

  seq_state_e       state_reg, state_next;
  word_idx_t        in_cnt_reg, out_cnt_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [31:0]      text_word_reg [WORDS_PER_BLOCK];
  logic [127:0]     buf_reg;
  logic             err_reg;

  logic accept;
  logic out_fire;
  logic done_capture;
  logic timeout_hit;

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    out_fire      = 1'b0;
    done_capture  = 1'b0;
    timeout_hit   = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
    bus.s_ready   = 1'b0;
    bus.m_valid   = 1'b0;
    bus.aes_ld    = 1'b0;
    case (state_reg)
      ST_FILL: begin
        // Not ready while reset is being applied, so no word slips in.
        bus.s_ready = !rst;
        accept      = bus.s_valid && !rst;
        if (accept && in_cnt_reg == LAST_IDX) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.aes_ld = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A done in the final timeout cycle still counts as a completion.
        done_capture = bus.aes_done;
        if (bus.aes_done)     state_next = ST_DRAIN;
        else if (timeout_hit) state_next = ST_FILL;
      end
      ST_DRAIN: begin
        bus.m_valid = 1'b1;
        out_fire    = bus.m_ready;
        if (out_fire && out_cnt_reg == LAST_IDX) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FILL;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      timer_reg   <= '0;
      buf_reg     <= '0;
      err_reg     <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) text_word_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)   in_cnt_reg  <= in_cnt_reg + 1'b1;
      if (out_fire) out_cnt_reg <= out_cnt_reg + 1'b1;
      timer_reg <= (state_reg == ST_WAIT) ? timer_reg + 1'b1 : '0;
      if (done_capture) buf_reg <= bus.aes_text_out;
      if (state_reg == ST_WAIT && !bus.aes_done && timeout_hit) err_reg <= 1'b1;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        if (accept && in_cnt_reg == word_idx_t'(i)) text_word_reg[i] <= bus.s_data;
      end
    end
  end

  // First accepted word lands in the most significant slot.
  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_text_in
    assign bus.aes_text_in[(WORDS_PER_BLOCK - 1 - gi) * 32 +: 32] = text_word_reg[gi];
  end

  assign bus.m_data  = block_word(buf_reg, out_cnt_reg);
  assign busy        = (state_reg != ST_FILL);
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer with a stub cipher core and a
// transaction-level reference model of words, blocks, latency and timeout.
module tb_aes_block_sequencer;
  import aes_pkg::*;

  localparam int           TMO     = 16;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err_timeout;

  aes_block_sequencer_if bus();

  aes_block_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stub cipher core ----------------
  logic         stub_done   = 1'b0;
  logic         manual_done = 1'b0;
  logic [127:0] stub_text   = '0;
  logic [127:0] manual_text = '0;
  int           core_lat    = 3;
  bit           core_en     = 1'b1;
  int           stub_cnt    = 0;
  int           done_pulses = 0;

  assign bus.aes_done     = stub_done | manual_done;
  assign bus.aes_text_out = manual_done ? manual_text : stub_text;

  function automatic logic [127:0] cipher(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[63:0], pt[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      stub_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_done = 1'b1;
          done_pulses++;
        end
      end
      if (bus.aes_ld && core_en) begin
        stub_text = cipher(bus.aes_text_in);
        stub_cnt  = core_lat;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  logic [31:0]  in_words  [$];
  logic [127:0] exp_blk_q [$];
  logic [31:0]  exp_out_q [$];
  int exp_ld_cyc = -1;
  int exp_mv_cyc = -1;
  int ld_cyc_m   = 0;
  int ld_count   = 0;
  int out_count  = 0;
  bit model_wait = 1'b0;
  bit err_model  = 1'b0;
  bit prev_mv    = 1'b0;
  bit mv_seen    = 1'b0;

  always @(negedge clk) begin
    check("err_timeout", 128'(err_timeout), 128'(err_model));
    if (bus.s_valid && bus.s_ready) begin
      in_words.push_back(bus.s_data);
      if (in_words.size() == WORDS_PER_BLOCK) begin
        exp_blk_q.push_back({in_words[0], in_words[1], in_words[2], in_words[3]});
        in_words.delete();
        exp_ld_cyc = cyc + 1;
      end
    end
    if (bus.aes_ld) begin
      ld_count++;
      check("ld_latency", 128'(cyc), 128'(exp_ld_cyc));
      check("ld_has_block", 128'(exp_blk_q.size()), 128'(1));
      if (exp_blk_q.size() > 0) check("aes_text_in", bus.aes_text_in, exp_blk_q.pop_front());
      model_wait = 1'b1;
      ld_cyc_m   = cyc;
    end else if (model_wait) begin
      if (bus.aes_done) begin
        model_wait = 1'b0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++)
          exp_out_q.push_back(bus.aes_text_out[127 - 32*i -: 32]);
        exp_mv_cyc = cyc + 1;
      end else if (cyc - ld_cyc_m == TMO) begin
        model_wait = 1'b0;
        err_model  = 1'b1;
      end
    end
    if (bus.m_valid && !prev_mv) check("m_valid_latency", 128'(cyc), 128'(exp_mv_cyc));
    if (bus.m_valid) mv_seen = 1'b1;
    if (bus.m_valid && bus.m_ready) begin
      out_count++;
      check("out_expected", 128'(exp_out_q.size() > 0), 128'(1));
      if (exp_out_q.size() > 0) check("m_data", 128'(bus.m_data), 128'(exp_out_q.pop_front()));
    end
    prev_mv = bus.m_valid;
    if (rst) begin
      in_words.delete();
      exp_blk_q.delete();
      exp_out_q.delete();
      model_wait = 1'b0;
      err_model  = 1'b0;
      exp_ld_cyc = -1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w, input bit hold);
    int n = 0;
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 200) begin
      tick();
      n++;
    end
    check("s_ready_wait", 128'(n < 200), 128'(1));
    tick();
    if (!hold) bus.s_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < WORDS_PER_BLOCK; i++) send_word(blk[127 - 32*i -: 32], 1'b0);
  endtask

  task automatic recv_word(input int stall, output logic [31:0] w);
    int n = 0;
    bus.m_ready = 1'b0;
    while (!bus.m_valid && n < 200) begin
      tick();
      n++;
    end
    check("m_valid_wait", 128'(n < 200), 128'(1));
    w = bus.m_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_m_data", 128'(bus.m_data), 128'(w));
      check("hold_m_valid", 128'(bus.m_valid), 128'(1));
      check("s_ready_drain", 128'(bus.s_ready), 128'(0));
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    $display("out word %08h after stall %0d", w, stall);
  endtask

  task automatic recv_block(input int stall);
    logic [31:0] w;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) recv_word(stall, w);
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] blk;
    logic [31:0]  w;
    int ld0, oc0, dp0, n;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_s_ready", 128'(bus.s_ready), 128'(0));
    check("rst_m_valid", 128'(bus.m_valid), 128'(0));
    check("rst_aes_ld", 128'(bus.aes_ld), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err_timeout), 128'(0));
    check("rst_text_in", bus.aes_text_in, 128'(0));
    check("rst_m_data", 128'(bus.m_data), 128'(0));
    rst = 1'b0;
    tick();
    check("post_rst_s_ready", 128'(bus.s_ready), 128'(1));

    // FIPS-197 vector through the stub core
    core_lat = 3;
    ld0 = ld_count;
    send_block(FIPS_PT);
    check("fips_ld_now", 128'(bus.aes_ld), 128'(1));
    ct = FIPS_CT;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      recv_word(0, w);
      check("fips_word", 128'(w), 128'(ct[127 - 32*i -: 32]));
    end
    check("fips_ld_count", 128'(ld_count - ld0), 128'(1));

    // done in the very last WAIT cycle wins over the timeout
    core_lat = TMO;
    send_block(rand_block());
    recv_block(0);
    check("late_done_no_err", 128'(err_timeout), 128'(0));

    // backpressure: five stall cycles per output word
    core_lat = int'($urandom_range(1, 8));
    send_block(rand_block());
    recv_block(5);

    // a few random blocks with random latency and stalls
    for (int b = 0; b < 3; b++) begin
      core_lat = int'($urandom_range(1, 15));
      send_block(rand_block());
      recv_block(int'($urandom_range(0, 3)));
    end

    // back-to-back: s_valid held high, m_ready held high
    core_lat = 2;
    ld0 = ld_count;
    oc0 = out_count;
    fork
      begin
        for (int i = 0; i < 3 * WORDS_PER_BLOCK; i++) send_word($urandom(), 1'b1);
        bus.s_valid = 1'b0;
      end
      begin
        int k = 0;
        bus.m_ready = 1'b1;
        while (out_count < oc0 + 3 * WORDS_PER_BLOCK && k < 2000) begin
          tick();
          k++;
        end
        bus.m_ready = 1'b0;
      end
    join
    check("b2b_words", 128'(out_count - oc0), 128'(3 * WORDS_PER_BLOCK));
    check("b2b_ld_count", 128'(ld_count - ld0), 128'(3));
    check("b2b_queue_empty", 128'(exp_out_q.size()), 128'(0));

    // timeout: core never answers
    core_en = 1'b0;
    tick();
    mv_seen = 1'b0;
    send_block(rand_block());
    check("tmo_ld_now", 128'(bus.aes_ld), 128'(1));
    repeat (TMO) tick();
    check("tmo_err_before", 128'(err_timeout), 128'(0));
    check("tmo_busy_before", 128'(busy), 128'(1));
    tick();
    check("tmo_err_after", 128'(err_timeout), 128'(1));
    check("tmo_busy_after", 128'(busy), 128'(0));
    check("tmo_s_ready", 128'(bus.s_ready), 128'(1));
    check("tmo_no_m_valid", 128'(mv_seen), 128'(0));
    core_en  = 1'b1;
    core_lat = 4;
    send_block(rand_block());
    recv_block(1);
    check("tmo_err_sticky", 128'(err_timeout), 128'(1));

    // reset while waiting; the stale done must be ignored
    core_lat = 10;
    send_block(rand_block());
    dp0 = done_pulses;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      tick();
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) n++;
    end
    check("rst_wait_quiet", 128'(n), 128'(0));
    check("rst_wait_stale_done", 128'(done_pulses - dp0), 128'(1));
    check("rst_wait_m_data", 128'(bus.m_data), 128'(0));
    check("rst_wait_err_clr", 128'(err_timeout), 128'(0));

    // stray done during FILL with two words accepted
    blk = rand_block();
    send_word(blk[127:96], 1'b0);
    send_word(blk[95:64], 1'b0);
    tick();
    manual_text = rand_block();
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    tick();
    check("stray_busy", 128'(busy), 128'(0));
    check("stray_s_ready", 128'(bus.s_ready), 128'(1));
    check("stray_m_data", 128'(bus.m_data), 128'(0));
    core_lat = 3;
    send_word(blk[63:32], 1'b0);
    send_word(blk[31:0], 1'b0);
    check("stray_ld_after_4", 128'(bus.aes_ld), 128'(1));
    check("stray_text_in", bus.aes_text_in, blk);
    recv_block(0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
